// File: rtl/ps2_keymatrix_pkg.sv
// Shared types and constants for the PS/2 to Plus/4 keyboard matrix decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_keymatrix_pkg;

   // Decoder sequence state
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXTBRK,
      ST_SKIP
   } state_t;

   // Set-2 prefix bytes
   localparam logic [7:0] SC_E0 = 8'hE0;
   localparam logic [7:0] SC_E1 = 8'hE1;
   localparam logic [7:0] SC_F0 = 8'hF0;
   localparam logic [7:0] SC_AA = 8'hAA;

   // Matrix coordinate; {row, col} doubles as the key_down bit index row*8+col
   typedef struct packed {
      logic [2:0] row;
      logic [2:0] col;
   } coord_t;

   // Keymap lookup result
   typedef struct packed {
      logic   valid;
      coord_t pos;
   } keymap_t;

   localparam coord_t KEY_RETURN  = '{row: 3'd0, col: 3'd1};
   localparam coord_t KEY_A       = '{row: 3'd1, col: 3'd2};
   localparam coord_t KEY_LSHIFT  = '{row: 3'd1, col: 3'd7};
   localparam coord_t KEY_SPACE   = '{row: 3'd7, col: 3'd4};
   localparam coord_t KEY_RUNSTOP = '{row: 3'd7, col: 3'd7};

   // Keyboard acks/errors/overruns that carry no key information
   function automatic logic is_ignored(input logic [7:0] code);
      return (code == 8'hFA) || (code == 8'hFE) || (code == 8'h00) || (code == 8'hFF);
   endfunction

   // Prefix bytes that must never be treated as a key code
   function automatic logic is_prefix(input logic [7:0] code);
      return (code == SC_E0) || (code == SC_E1) || (code == SC_F0);
   endfunction

endpackage

// File: rtl/ps2_keymatrix_if.sv
// Byte-in / matrix-out bundle between PS/2 receiver, keyboard latch and TED.
// Latency: n/a (wiring only).
// Backpressure: none; rx_done is a one-cycle strobe that is always accepted.
interface ps2_keymatrix_if;
   logic       rx_done;
   logic [7:0] scancode;
   logic [7:0] row_sel_n;
   logic [7:0] col_n;
   logic       reset_req;

   modport master (output rx_done, scancode, row_sel_n, input col_n, reset_req);
   modport slave  (input rx_done, scancode, row_sel_n, output col_n, reset_req);
endinterface

// File: rtl/ps2_keymap.sv
// Combinational ROM mapping {ext, set-2 code} to a Plus/4 matrix coordinate.
// Latency: 0 cycles (pure logic).
// Backpressure: none.
module ps2_keymap
   import ps2_keymatrix_pkg::*;
(
   input  logic       ext,
   input  logic [7:0] code,
   output keymap_t    map
);

   function automatic keymap_t mk(input logic [5:0] rc);
      return {1'b1, rc};
   endfunction

   // Table lookup; coordinates written as octal {row, col}
   always_comb begin
      map = '0;
      case ({ext, code})
         // row 0: DEL RETURN pound HELP F1 F2 F3 @
         9'h066: map = mk(6'o00);  9'h05A: map = mk(6'o01);  9'h05D: map = mk(6'o02);
         9'h00C: map = mk(6'o03);  9'h005: map = mk(6'o04);  9'h006: map = mk(6'o05);
         9'h004: map = mk(6'o06);  9'h054: map = mk(6'o07);
         // row 1: 3 W A 4 Z S E SHIFT (both PC shifts)
         9'h026: map = mk(6'o10);  9'h01D: map = mk(6'o11);  9'h01C: map = mk(6'o12);
         9'h025: map = mk(6'o13);  9'h01A: map = mk(6'o14);  9'h01B: map = mk(6'o15);
         9'h024: map = mk(6'o16);  9'h012: map = mk(6'o17);  9'h059: map = mk(6'o17);
         // row 2: 5 R D 6 C F T X
         9'h02E: map = mk(6'o20);  9'h02D: map = mk(6'o21);  9'h023: map = mk(6'o22);
         9'h036: map = mk(6'o23);  9'h021: map = mk(6'o24);  9'h02B: map = mk(6'o25);
         9'h02C: map = mk(6'o26);  9'h022: map = mk(6'o27);
         // row 3: 7 Y G 8 B H U V
         9'h03D: map = mk(6'o30);  9'h035: map = mk(6'o31);  9'h034: map = mk(6'o32);
         9'h03E: map = mk(6'o33);  9'h032: map = mk(6'o34);  9'h033: map = mk(6'o35);
         9'h03C: map = mk(6'o36);  9'h02A: map = mk(6'o37);
         // row 4: 9 I J 0 M K O N
         9'h046: map = mk(6'o40);  9'h043: map = mk(6'o41);  9'h03B: map = mk(6'o42);
         9'h045: map = mk(6'o43);  9'h03A: map = mk(6'o44);  9'h042: map = mk(6'o45);
         9'h044: map = mk(6'o46);  9'h031: map = mk(6'o47);
         // row 5: DOWN P L UP . : - ,
         9'h04D: map = mk(6'o51);  9'h04B: map = mk(6'o52);  9'h049: map = mk(6'o54);
         9'h052: map = mk(6'o55);  9'h04E: map = mk(6'o56);  9'h041: map = mk(6'o57);
         // row 6: LEFT * ; RIGHT ESC = + /
         9'h05B: map = mk(6'o61);  9'h04C: map = mk(6'o62);  9'h076: map = mk(6'o64);
         9'h055: map = mk(6'o65);  9'h00E: map = mk(6'o66);  9'h04A: map = mk(6'o67);
         // row 7: 1 CLR/HOME CTRL 2 SPACE C= Q RUN/STOP
         9'h016: map = mk(6'o70);  9'h014: map = mk(6'o72);  9'h01E: map = mk(6'o73);
         9'h029: map = mk(6'o74);  9'h011: map = mk(6'o75);  9'h015: map = mk(6'o76);
         9'h00D: map = mk(6'o77);
         // extended keys
         9'h171: map = mk(6'o00);  9'h15A: map = mk(6'o01);  9'h172: map = mk(6'o50);
         9'h175: map = mk(6'o53);  9'h16B: map = mk(6'o60);  9'h174: map = mk(6'o63);
         9'h14A: map = mk(6'o67);  9'h16C: map = mk(6'o71);  9'h114: map = mk(6'o72);
         9'h111: map = mk(6'o75);
         // fake shifts wrapped around navigation keys must not touch SHIFT
         9'h112, 9'h159: map = '0;
         default: map = '0;
      endcase
   end

endmodule

// File: rtl/ps2_keymatrix.sv
// Decodes PS/2 set-2 make/break/extended bytes into a 64-key Plus/4 matrix for TED.
// Latency: key_down updates 1 cycle after rx_done; col_n 1 cycle after key_down/row_sel_n.
// Backpressure: none; every rx_done byte is consumed. Optional PS2KEYMATRIX_RESETKEY_EN adds Ctrl+Alt+Del reset_req.
module ps2_keymatrix
   import ps2_keymatrix_pkg::*;
#(
   parameter int PAUSE_SKIP = 7
)(
   input  logic             clk,
   input  logic             reset,
   ps2_keymatrix_if.slave   bus
);

   localparam int SKW = $clog2(PAUSE_SKIP + 1);

   state_t           state, state_nxt;
   logic [SKW-1:0]   skip_cnt;
   logic [63:0]      key_down;
   logic [7:0]       col_q;
   logic [7:0]       col_hit;
   logic             ext, do_make, do_break, clr_all, skip_load, skip_dec;
   keymap_t          lookup;

   ps2_keymap u_keymap (
      .ext  (ext),
      .code (bus.scancode),
      .map  (lookup)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode, advancing only on a received byte
   always_comb begin
      state_nxt = state;
      if (bus.rx_done) begin
         case (state)
            ST_IDLE: begin
               if      (bus.scancode == SC_E0) state_nxt = ST_EXT;
               else if (bus.scancode == SC_F0) state_nxt = ST_BRK;
               else if (bus.scancode == SC_E1) state_nxt = ST_SKIP;
            end
            ST_EXT:  state_nxt = (bus.scancode == SC_F0) ? ST_EXTBRK : ST_IDLE;
            ST_SKIP: if (skip_cnt <= SKW'(1)) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Per-byte actions derived from state and the incoming byte
   always_comb begin
      ext       = 1'b0;
      do_make   = 1'b0;
      do_break  = 1'b0;
      clr_all   = 1'b0;
      skip_load = 1'b0;
      skip_dec  = 1'b0;
      case (state)
         ST_IDLE: if (bus.rx_done) begin
            if      (bus.scancode == SC_E1) skip_load = 1'b1;
            else if (bus.scancode == SC_AA) clr_all   = 1'b1;
            else if (!is_prefix(bus.scancode) && !is_ignored(bus.scancode)) do_make = 1'b1;
         end
         ST_EXT: begin
            ext     = 1'b1;
            do_make = bus.rx_done && !is_prefix(bus.scancode);
         end
         ST_BRK:    do_break = bus.rx_done && !is_prefix(bus.scancode);
         ST_EXTBRK: begin
            ext      = 1'b1;
            do_break = bus.rx_done;
         end
         ST_SKIP:   skip_dec = bus.rx_done;
         default: ;
      endcase
   end

   // Pause-sequence byte counter
   always_ff @(posedge clk) begin
      if (reset)          skip_cnt <= '0;
      else if (skip_load) skip_cnt <= SKW'(PAUSE_SKIP);
      else if (skip_dec)  skip_cnt <= skip_cnt - SKW'(1);
   end

   // Matrix state: make sets, any break clears, AA wipes everything
   always_ff @(posedge clk) begin
      if (reset || clr_all)               key_down <= '0;
      else if (do_make && lookup.valid)   key_down[lookup.pos] <= 1'b1;
      else if (do_break && lookup.valid)  key_down[lookup.pos] <= 1'b0;
   end

   // OR together the key rows selected by the active-low latch value
   always_comb begin
      col_hit = '0;
      for (int r = 0; r < 8; r++)
         if (!bus.row_sel_n[r]) col_hit = col_hit | key_down[r*8 +: 8];
   end

   // Registered active-low column data for TED
   always_ff @(posedge clk) begin
      if (reset) col_q <= 8'hFF;
      else       col_q <= ~col_hit;
   end

   assign bus.col_n = col_q;

`ifdef PS2KEYMATRIX_RESETKEY_EN
   logic ctrl_held, alt_held, del_held, reset_req_q;

   // Ctrl/Alt/Delete tracking, independent of the matrix map
   always_ff @(posedge clk) begin
      if (reset || clr_all) begin
         ctrl_held <= 1'b0;
         alt_held  <= 1'b0;
         del_held  <= 1'b0;
      end else if (do_make || do_break) begin
         if (bus.scancode == 8'h14)        ctrl_held <= do_make;
         if (bus.scancode == 8'h11)        alt_held  <= do_make;
         if (ext && bus.scancode == 8'h71) del_held  <= do_make;
      end
   end

   // Request asserted the cycle after all three are held
   always_ff @(posedge clk) begin
      if (reset) reset_req_q <= 1'b0;
      else       reset_req_q <= ctrl_held && alt_held && del_held;
   end

   assign bus.reset_req = reset_req_q;
`else
   assign bus.reset_req = 1'b0;
`endif

endmodule
